pixel_readout: RTL and testbench

Receive-side readout block for the pixel array. During the read phase driven by `data_path`, it samples the digital value on the pixel array's output bus once per selected pixel. It tags each sample with its index and frame-boundary flags and buffers it in a small FIFO. It presents the samples to downstream logic over a valid/ready stream. It sits beside `pixel_array` inside `pixel_top` and observes the same `erase`/`read`/`pixel_select` control bus.

---
 rtl/pixel_readout.sv | 148 ++++++++++++++
 tb/tb_pixel_readout.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - captures one sample per selected pixel per frame into a tagged FIFO
// Output is a valid/ready stream of {data, index, first, last}, with frame completion tracking.
module pixel_readout #(
  parameter int pixel_count = 4,
  parameter int bit_depth   = 8,
  parameter int fifo_depth  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           erase,
  input  logic                           read,
  input  logic [$clog2(pixel_count)-1:0] pixel_select,
  input  logic [bit_depth-1:0]           pixel_data,
  output logic [bit_depth-1:0]           out_data,
  output logic [$clog2(pixel_count)-1:0] out_index,
  output logic                           out_first,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_done,
  output logic [7:0]                     frame_count,
  output logic                           overflow
);

  localparam int SW = $clog2(pixel_count);
  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(fifo_depth);

  typedef struct packed {
    logic [bit_depth-1:0] data;
    logic [SW-1:0]        index;
    logic                 first;
    logic                 last;
  } entry_t;

  entry_t                   mem_q [fifo_depth];
  entry_t                   mem_d [fifo_depth];
  logic [pixel_count-1:0]   seen_q, seen_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     frame_done_q, frame_done_d;
  logic [7:0]               frame_count_q, frame_count_d;
  logic                     overflow_q, overflow_d;

  logic                     sel_ok;
  logic [pixel_count-1:0]   onehot;
  logic                     cap;
  logic                     is_first;
  logic                     is_last;
  logic                     head_valid;
  logic                     pop;
  logic                     push;
  entry_t                   head;

  always_comb begin
    sel_ok     = 32'(pixel_select) < pixel_count;
    onehot     = sel_ok ? (pixel_count'(1) << pixel_select) : '0;
    // Out-of-range selects yield an empty onehot, so they can never capture.
    cap        = read & ~erase & sel_ok & ~(|(seen_q & onehot));
    is_first   = (seen_q == '0);
    is_last    = ((seen_q | onehot) == '1);
    head_valid = (count_q != '0);
    pop        = head_valid & out_ready;
    push       = cap & ((count_q != FULL) | pop);
  end

  always_comb begin
    mem_d         = mem_q;
    seen_d        = seen_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;

    if (erase) begin
      seen_d = '0;
    end else if (cap) begin
      seen_d = seen_q | onehot;
    end

    // A dropped capture still counts toward frame completion.
    if (cap && is_last) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
    end

    if (cap && !push) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = '{data: pixel_data, index: pixel_select,
                          first: is_first, last: is_last};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      seen_q        <= seen_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_valid   = head_valid;
    out_data    = head_valid ? head.data  : '0;
    out_index   = head_valid ? head.index : '0;
    out_first   = head_valid & head.first;
    out_last    = head_valid & head.last;
    frame_done  = frame_done_q;
    frame_count = frame_count_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_pixel_readout.sv
// tb/tb_pixel_readout.sv - self-checking bench for pixel_readout
// Table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_pixel_readout;

  localparam int PC = 4;
  localparam int BD = 8;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       erase;
  logic       read;
  logic [1:0] pixel_select;
  logic [7:0] pixel_data;
  logic [7:0] out_data;
  logic [1:0] out_index;
  logic       out_first;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_readout #(.pixel_count(PC), .bit_depth(BD), .fifo_depth(FD)) dut (
    .clk(clk), .reset(reset), .erase(erase), .read(read),
    .pixel_select(pixel_select), .pixel_data(pixel_data),
    .out_data(out_data), .out_index(out_index), .out_first(out_first),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       first;
    logic       last;
  } ent_t;

  ent_t     m_q[$];
  bit [3:0] m_seen;
  bit [7:0] m_fc;
  bit       m_ovf;
  bit       m_done;

  typedef struct {
    logic       er;
    logic       rd;
    logic [1:0] sel;
    logic [7:0] dat;
    logic       rdy;
    logic       v;
    logic [7:0] d;
    logic [1:0] idx;
    logic       f;
    logic       l;
    logic       done;
    logic [7:0] fc;
    logic       ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: spec rules applied to a queue, evaluated once per clock edge.
  task automatic model_edge(input bit rst, input bit er, input bit rd,
                            input int sel, input logic [7:0] dat, input bit rdy);
    bit cap, first, last;
    ent_t e;
    m_done = 0;
    if (rst) begin
      m_q.delete();
      m_seen = 0;
      m_fc   = 0;
      m_ovf  = 0;
      return;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    cap = rd && !er && sel < PC && !m_seen[sel];
    if (cap) begin
      first = (m_seen == 0);
      m_seen[sel] = 1'b1;
      last  = (m_seen == 4'hF);
      e = '{data: dat, idx: 2'(sel), first: first, last: last};
      if (m_q.size() < FD) m_q.push_back(e);
      else m_ovf = 1;
      if (last) begin
        m_done = 1;
        m_fc   = m_fc + 1;
      end
    end
    if (er) m_seen = 0;
  endtask

  task automatic check_model();
    chk("valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("data",  out_data,  m_q[0].data);
      chk("index", out_index, m_q[0].idx);
      chk("first", out_first, m_q[0].first);
      chk("last",  out_last,  m_q[0].last);
    end
    chk("frame_done",  frame_done,  m_done);
    chk("frame_count", frame_count, m_fc);
    chk("overflow",    overflow,    m_ovf);
  endtask

  task automatic step(input bit rst, input bit er, input bit rd,
                      input int sel, input logic [7:0] dat, input bit rdy);
    reset        = rst;
    erase        = er;
    read         = rd;
    pixel_select = 2'(sel);
    pixel_data   = dat;
    out_ready    = rdy;
    @(posedge clk);
    model_edge(rst, er, rd, sel, dat, rdy);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    reset = 1; erase = 0; read = 0; pixel_select = 0; pixel_data = 0; out_ready = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);

    chk("rst out_valid",   out_valid,   0);
    chk("rst out_data",    out_data,    0);
    chk("rst out_index",   out_index,   0);
    chk("rst out_first",   out_first,   0);
    chk("rst out_last",    out_last,    0);
    chk("rst frame_done",  frame_done,  0);
    chk("rst frame_count", frame_count, 0);
    chk("rst overflow",    overflow,    0);

    // Single frame then duplicate-select hold.
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'h10, 1'b1, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 8'h20, 1'b1, 1'b1, 8'h20, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 8'h30, 1'b1, 1'b1, 8'h30, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'd3, 8'h40, 1'b1, 1'b1, 8'h40, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 8'hAA, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 8'hAA, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 8'hBB, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 8'hBB, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].er, tbl[i].rd, tbl[i].sel, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("tbl%0d valid", i), out_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d data", i),  out_data,  tbl[i].d);
        chk($sformatf("tbl%0d index", i), out_index, tbl[i].idx);
        chk($sformatf("tbl%0d first", i), out_first, tbl[i].f);
        chk($sformatf("tbl%0d last", i),  out_last,  tbl[i].l);
      end
      chk($sformatf("tbl%0d done", i), frame_done,  tbl[i].done);
      chk($sformatf("tbl%0d fc", i),   frame_count, tbl[i].fc);
      chk($sformatf("tbl%0d ovf", i),  overflow,    tbl[i].ovf);
    end

    // Backpressure fills the FIFO, next frame's first capture is dropped.
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, i, 8'(i + 1), 0);
    chk("bp full valid", out_valid, 1);
    chk("bp full ovf",   overflow,  0);
    step(0, 1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'h55, 0);
    chk("bp drop ovf",  overflow, 1);
    chk("bp drop head", out_data, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("bp drain data", out_data, 8'(i + 1));
      step(0, 0, 0, 0, 8'h00, 1);
    end
    chk("bp drained", out_valid, 0);
    chk("bp ovf sticky", overflow, 1);

    // Push and pop together on a full FIFO.
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, i, 8'h60 + 8'(i), 0);
    step(0, 1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'h70, 1);
    chk("pp ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pp drain data", out_data, (i < 3) ? 8'h61 + 8'(i) : 8'h70);
      step(0, 0, 0, 0, 8'h00, 1);
    end
    chk("pp drained", out_valid, 0);

    // Erase beats a simultaneous read.
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 8'h00, 1);
    step(0, 0, 1, 1, 8'h11, 1);
    step(0, 1, 1, 1, 8'h22, 1);
    chk("ep no capture", out_valid, 0);
    step(0, 0, 1, 1, 8'h33, 1);
    chk("ep valid", out_valid, 1);
    chk("ep data",  out_data,  8'h33);
    chk("ep first", out_first, 1);

    // Reset mid-frame, then 256 frames to wrap the frame counter.
    step(0, 1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'hC0, 0);
    step(0, 0, 1, 1, 8'hC1, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk("mr valid", out_valid,   0);
    chk("mr fc",    frame_count, 0);
    step(0, 0, 1, 2, 8'hC2, 0);
    chk("mr first", out_first, 1);
    chk("mr index", out_index, 2);
    step(1, 0, 0, 0, 8'h00, 0);
    for (int f = 0; f < 256; f++) begin
      step(0, 1, 0, 0, 8'h00, 1);
      for (int p = 0; p < 4; p++) step(0, 0, 1, p, 8'($urandom), 1);
      if (f == 254) chk("wrap fc255", frame_count, 8'd255);
    end
    chk("wrap fc0", frame_count, 8'd0);

    // Random traffic against the model.
    step(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
